// File: rtl/pmem_line_responder_pkg.sv
// Shared types and constants for the pmem line responder.
// Line geometry and the responder state encoding live here.
package pmem_pkg;

  localparam int LINE_W   = 128;
  localparam int WORD_W   = 32;
  localparam int BEATS    = 4;
  localparam int OFFSET_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    XFER_RD,
    XFER_WR,
    RESP
  } pmem_state_t;

endpackage

// File: rtl/pmem_line_responder_wait_counter.sv
// Loadable down-counter for the pre-transfer access delay.
// done is high on the last cycle of the programmed delay.
module pmem_wait_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] value,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= value;
    end else if (en && count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign done = (count <= W'(1));

endmodule

// File: rtl/pmem_line_responder.sv
// Memory-side responder: serves 128-bit line requests
// from a 32-bit synchronous SRAM in four word beats.
module pmem_line_responder
  import pmem_pkg::*;
#(
  parameter int ADDR_W      = 16,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [ADDR_W-1:0] pmem_address,
  input  logic [LINE_W-1:0] pmem_wdata,
  output logic [LINE_W-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic [ADDR_W-3:0] sram_addr,
  output logic              sram_we,
  output logic [WORD_W-1:0] sram_wdata,
  input  logic [WORD_W-1:0] sram_rdata
);

  localparam int LINE_AW = ADDR_W - OFFSET_W;

  pmem_state_t state, state_next;

  logic [LINE_AW-1:0] line;
  logic [LINE_W-1:0]  wdata;
  logic               is_write;
  logic [2:0]         beat;
  logic [1:0]         cap_idx;
  logic               req;
  logic               accept;
  logic               wait_done;
  logic               unused;

  assign req     = pmem_read | pmem_write;
  assign accept  = (state == IDLE) && req;
  assign cap_idx = beat[1:0] - 2'd1;
  assign unused  = ^pmem_address[OFFSET_W-1:0];

  pmem_wait_counter #(
    .W(8)
  ) u_wait (
    .clk  (clk),
    .rst_n(rst_n),
    .load (accept),
    .en   (state == WAIT),
    .value(8'(WAIT_CYCLES)),
    .done (wait_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (WAIT_CYCLES > 0) begin
            state_next = WAIT;
          end else begin
            state_next = pmem_write ? XFER_WR : XFER_RD;
          end
        end
      end
      WAIT: begin
        if (wait_done) begin
          state_next = is_write ? XFER_WR : XFER_RD;
        end
      end
      XFER_WR: if (beat == 3'd3) state_next = RESP;
      XFER_RD: if (beat == 3'd4) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Read beat k lands one cycle after its address, so
  // capture trails the address phase by one beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line       <= '0;
      wdata      <= '0;
      is_write   <= 1'b0;
      beat       <= '0;
      pmem_rdata <= '0;
    end else begin
      if (accept) begin
        line     <= pmem_address[ADDR_W-1:OFFSET_W];
        wdata    <= pmem_wdata;
        is_write <= pmem_write;
      end
      if (state == XFER_RD || state == XFER_WR) begin
        beat <= beat + 3'd1;
      end else begin
        beat <= '0;
      end
      if (state == XFER_RD && beat != 3'd0) begin
        pmem_rdata[{cap_idx, 5'd0} +: WORD_W] <= sram_rdata;
      end
    end
  end

  always_comb begin
    pmem_resp  = 1'b0;
    sram_we    = 1'b0;
    sram_addr  = '0;
    sram_wdata = '0;
    case (state)
      XFER_WR: begin
        sram_we    = 1'b1;
        sram_addr  = {line, beat[1:0]};
        sram_wdata = wdata[{beat[1:0], 5'd0} +: WORD_W];
      end
      XFER_RD: begin
        if (!beat[2]) sram_addr = {line, beat[1:0]};
      end
      RESP:    pmem_resp = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Scoreboard bench: two responders (delay 2 and 0) behind
// behavioural SRAMs, checked against a line-level model.
module tb_pmem_line_responder;

  localparam int AW  = 16;
  localparam int SAW = AW - 2;
  localparam int NW  = 1 << SAW;

  logic clk = 1'b0;
  logic rst_n;

  logic           rd     [2];
  logic           wr     [2];
  logic [AW-1:0]  addr   [2];
  logic [127:0]   wdat   [2];
  logic [127:0]   rdat   [2];
  logic           resp   [2];
  logic [SAW-1:0] saddr  [2];
  logic           swe    [2];
  logic [31:0]    swdata [2];
  logic [31:0]    srdata [2];

  logic [31:0] sram [2][NW];
  logic [31:0] refm [2][NW];

  typedef struct {
    int           cyc;
    bit           is_rd;
    logic [127:0] data;
  } rexp_t;

  typedef struct {
    logic [SAW-1:0] a;
    logic [31:0]    w;
  } wexp_t;

  rexp_t rq[$];
  wexp_t wq[$];
  rexp_t er;
  wexp_t ew;

  int  sel = 0;
  int  cyc = 0;
  int  errors = 0;
  int  checks = 0;
  int  beats_seen = 0;
  bit  prev_resp [2];

  genvar g;
  for (g = 0; g < 2; g = g + 1) begin : g_dut
    pmem_line_responder #(
      .ADDR_W     (AW),
      .WAIT_CYCLES(g == 0 ? 2 : 0)
    ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .pmem_read   (rd[g]),
      .pmem_write  (wr[g]),
      .pmem_address(addr[g]),
      .pmem_wdata  (wdat[g]),
      .pmem_rdata  (rdat[g]),
      .pmem_resp   (resp[g]),
      .sram_addr   (saddr[g]),
      .sram_we     (swe[g]),
      .sram_wdata  (swdata[g]),
      .sram_rdata  (srdata[g])
    );
  end

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      srdata[d] <= sram[d][saddr[d]];
      if (swe[d]) sram[d][saddr[d]] <= swdata[d];
    end
  end

  task automatic chk(input string name,
                     input logic [127:0] act,
                     input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        if (resp[d]) begin
          chk("resp_expected",
              {d == sel, rq.size() != 0}, 2'b11);
          chk("resp_width", prev_resp[d], 0);
          if (d == sel && rq.size() != 0) begin
            er = rq.pop_front();
            chk("resp_cycle", cyc, er.cyc);
            if (er.is_rd) chk("rdata", rdat[d], er.data);
          end
        end
        if (swe[d]) begin
          chk("we_expected",
              {d == sel, wq.size() != 0}, 2'b11);
          if (d == sel && wq.size() != 0) begin
            ew = wq.pop_front();
            chk("we_addr", saddr[d], ew.a);
            chk("we_data", swdata[d], ew.w);
            beats_seen++;
          end
        end
        prev_resp[d] = resp[d];
      end
    end
  end

  function automatic logic [127:0] ref_line(
      input logic [SAW-3:0] ln);
    logic [127:0] l;
    for (int b = 0; b < 4; b++) begin
      l[32*b +: 32] = refm[sel][{ln, 2'(b)}];
    end
    return l;
  endfunction

  // mode 1: scramble addr/data next cycle; mode 2: also drop req
  task automatic req(input bit do_wr, input bit do_rd,
                     input logic [AW-1:0] a,
                     input logic [127:0] data,
                     input int mode);
    logic [SAW-3:0] ln;
    int lat;
    int n;
    ln = a[AW-1:4];
    rd[sel]   = do_rd;
    wr[sel]   = do_wr;
    addr[sel] = a;
    wdat[sel] = data;
    lat = (sel == 0 ? 2 : 0) + (do_wr ? 5 : 6);
    if (do_wr) begin
      for (int b = 0; b < 4; b++) begin
        wq.push_back('{a: {ln, 2'(b)}, w: data[32*b +: 32]});
        refm[sel][{ln, 2'(b)}] = data[32*b +: 32];
      end
    end
    rq.push_back('{cyc: cyc + lat, is_rd: !do_wr,
                   data: ref_line(ln)});
    if (mode != 0) begin
      @(posedge clk);
      #1;
      addr[sel] = AW'($urandom);
      wdat[sel] = {$urandom, $urandom, $urandom, $urandom};
      if (mode == 2) begin
        rd[sel] = 1'b0;
        wr[sel] = 1'b0;
      end
    end
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!resp[sel] && n < 300);
    chk("resp_timeout", n < 300, 1);
    @(posedge clk);
    #1;
    rd[sel] = 1'b0;
    wr[sel] = 1'b0;
  endtask

  task automatic rand_ops(input int cnt);
    logic [AW-1:0] a;
    logic [127:0]  dt;
    int op;
    int mode;
    for (int i = 0; i < cnt; i++) begin
      a    = {8'h3C, 4'($urandom_range(0, 15)), 4'($urandom)};
      dt   = {$urandom, $urandom, $urandom, $urandom};
      op   = int'($urandom_range(0, 3));
      mode = 0;
      if (sel == 0 && $urandom_range(0, 4) == 0) mode = 1;
      req(op == 1 || op == 2, op != 1, a, dt, mode);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic chk_reset(input int d);
    chk("rst_resp", resp[d], 0);
    chk("rst_we", swe[d], 0);
    chk("rst_addr", saddr[d], 0);
    chk("rst_wdata", swdata[d], 0);
    chk("rst_rdata", rdat[d], 0);
  endtask

  task automatic abort_test();
    logic [SAW-3:0] ln;
    logic [127:0]   dt;
    int start;
    int n;
    ln = 12'h2A5;
    dt = {$urandom, $urandom, $urandom, $urandom};
    wr[0]   = 1'b1;
    addr[0] = {ln, 4'h0};
    wdat[0] = dt;
    for (int b = 0; b < 4; b++) begin
      wq.push_back('{a: {ln, 2'(b)}, w: dt[32*b +: 32]});
      if (b < 2) refm[0][{ln, 2'(b)}] = dt[32*b +: 32];
    end
    start = beats_seen;
    n = 0;
    while (beats_seen < start + 2 && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("abort_beats", beats_seen - start, 2);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset(0);
    wq.delete();
    wr[0] = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_no_resp", resp[0], 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    req(0, 1, {ln, 4'h7}, '0, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      rd[d]        = 1'b0;
      wr[d]        = 1'b0;
      addr[d]      = '0;
      wdat[d]      = '0;
      prev_resp[d] = 1'b0;
      for (int i = 0; i < NW; i++) begin
        sram[d][i] <= 32'h0;
        refm[d][i] = 32'h0;
      end
    end
    repeat (3) @(negedge clk);
    chk_reset(0);
    chk_reset(1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    sel = 0;
    req(1, 0, 16'h1230,
        128'h0123456789ABCDEF_FEDCBA9876543210, 0);
    req(0, 1, 16'h1230, '0, 0);
    req(0, 1, 16'h123F, '0, 0);
    req(1, 0, 16'h4560, {4{$urandom}}, 0);
    req(0, 1, 16'h7890, '0, 0);
    req(1, 0, 16'h1230, {4{$urandom}}, 1);
    req(0, 1, 16'h1234, '0, 0);
    req(0, 1, 16'h4568, '0, 2);
    rand_ops(30);
    abort_test();

    sel = 1;
    req(1, 1, 16'h0AB0, {4{$urandom}}, 0);
    req(0, 1, 16'h0AB4, '0, 0);
    rand_ops(30);

    chk("rq_drained", rq.size(), 0);
    chk("wq_drained", wq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
